// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and the common word type.
package mips_pkg;

    localparam int WORD_W       = 32;
    localparam int BRANCH_SHIFT = 2;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/left_shift_core.sv
// Combinational fixed-amount logical left shift with a lost-bits indicator.
module left_shift_core
    import mips_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int SHIFT = BRANCH_SHIFT
) (
    input  logic [WIDTH-1:0] in_word,
    output logic [WIDTH-1:0] shifted,
    output logic             lost
);

    assign shifted = in_word << SHIFT;

    // A zero-width part-select is illegal, so SHIFT=0 gets its own branch.
    generate
        if (SHIFT == 0) begin : g_no_shift
            assign lost = 1'b0;
        end else begin : g_shift
            assign lost = |in_word[WIDTH-1 -: SHIFT];
        end
    endgenerate

endmodule

// File: rtl/left_shifter.sv
// Registered left shifter: word offset to byte offset, with valid and overflow.
module left_shifter
    import mips_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int SHIFT = BRANCH_SHIFT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] In,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Out,
    output logic             out_valid,
    output logic             overflow
);

    logic [WIDTH-1:0] shifted;
    logic             lost;

    logic [WIDTH-1:0] out_q, out_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;

    left_shift_core #(
        .WIDTH (WIDTH),
        .SHIFT (SHIFT)
    ) u_core (
        .in_word (In),
        .shifted (shifted),
        .lost    (lost)
    );

    // In is only looked at under in_valid, so an X on an idle bus never reaches the registers.
    always_comb begin
        out_d   = out_q;
        ovf_d   = ovf_q;
        valid_d = in_valid;
        if (in_valid) begin
            out_d = shifted;
            ovf_d = lost;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign Out       = out_q;
    assign out_valid = valid_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_left_shifter.sv
// Self-checking bench for left_shifter against an arithmetic reference model.
module tb_left_shifter;
    import mips_pkg::*;

    logic  clk = 1'b0;
    logic  reset;
    word_t in_w;
    logic  in_v;
    word_t out_w;
    logic  out_v;
    logic  ovf;

    logic        r16;
    logic [15:0] in16;
    logic        v16;
    logic [15:0] o0, o4;
    logic        ov0, ov4, vv0, vv4;

    int checks = 0;
    int errors = 0;

    // Reference state: what the outputs should show after the latest edge.
    longint unsigned m_out;
    logic            m_ovf;
    logic            m_val;

    always #5 clk = ~clk;

    left_shifter dut (
        .clk       (clk),
        .reset     (reset),
        .In        (in_w),
        .in_valid  (in_v),
        .Out       (out_w),
        .out_valid (out_v),
        .overflow  (ovf)
    );

    left_shifter #(.WIDTH(16), .SHIFT(0)) dut_s0 (
        .clk       (clk),
        .reset     (r16),
        .In        (in16),
        .in_valid  (v16),
        .Out       (o0),
        .out_valid (vv0),
        .overflow  (ov0)
    );

    left_shifter #(.WIDTH(16), .SHIFT(4)) dut_s4 (
        .clk       (clk),
        .reset     (r16),
        .In        (in16),
        .in_valid  (v16),
        .Out       (o4),
        .out_valid (vv4),
        .overflow  (ov4)
    );

    // Multiply by 2**s modulo 2**w; overflow when the value needs more than w-s bits.
    function automatic longint unsigned ref_shift(longint unsigned x, int w, int s);
        return (x * (64'd1 << s)) % (64'd1 << w);
    endfunction

    function automatic logic ref_ovf(longint unsigned x, int w, int s);
        return (x / (64'd1 << (w - s))) != 0;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, then compare.
    task automatic tick(input string tag, input logic r, input logic v, input word_t d);
        reset = r;
        in_v  = v;
        in_w  = d;
        @(posedge clk);
        if (r) begin
            m_out = 0;
            m_ovf = 1'b0;
            m_val = 1'b0;
        end else if (v) begin
            m_out = ref_shift(longint'(d), 32, 2);
            m_ovf = ref_ovf(longint'(d), 32, 2);
            m_val = 1'b1;
        end else begin
            m_val = 1'b0;
        end
        #2;
        check_val({tag, ".out"}, out_w, m_out[31:0]);
        check_val({tag, ".vld"}, {31'b0, out_v}, {31'b0, m_val});
        check_val({tag, ".ovf"}, {31'b0, ovf}, {31'b0, m_ovf});
    endtask

    task automatic tick16(input string tag, input logic [15:0] d);
        longint unsigned e;
        in16 = d;
        v16  = 1'b1;
        r16  = 1'b0;
        @(posedge clk);
        #2;
        e = ref_shift(longint'(d), 16, 0);
        check_val({tag, ".s0.out"}, {16'b0, o0}, e[31:0]);
        check_val({tag, ".s0.ovf"}, {31'b0, ov0}, {31'b0, ref_ovf(longint'(d), 16, 0)});
        e = ref_shift(longint'(d), 16, 4);
        check_val({tag, ".s4.out"}, {16'b0, o4}, e[31:0]);
        check_val({tag, ".s4.ovf"}, {31'b0, ov4}, {31'b0, ref_ovf(longint'(d), 16, 4)});
        check_val({tag, ".s4.vld"}, {31'b0, vv4}, 32'd1);
    endtask

    initial begin
        word_t d;
        m_out = 0;
        m_ovf = 1'b0;
        m_val = 1'b0;
        r16   = 1'b1;
        in16  = 16'hFFFF;
        v16   = 1'b1;

        // Reset held with a live all-ones input.
        tick("rst0", 1'b1, 1'b1, 32'hFFFF_FFFF);
        tick("rst1", 1'b1, 1'b1, 32'hFFFF_FFFF);
        check_val("rst.s4.out", {16'b0, o4}, 32'd0);
        check_val("rst.s0.vld", {31'b0, vv0}, 32'd0);
        r16 = 1'b0;
        v16 = 1'b0;
        tick("idle", 1'b0, 1'b0, 32'hFFFF_FFFF);
        check_val("idle.zero", out_w, 32'd0);

        tick("b10", 1'b0, 1'b1, 32'd10);
        check_val("b10.const", out_w, 32'd40);
        tick("b100", 1'b0, 1'b1, 32'd100);
        check_val("b100.const", out_w, 32'h190);
        tick("hold", 1'b0, 1'b0, 'x);
        check_val("hold.const", out_w, 32'd400);
        tick("holdx", 1'b0, 1'b0, 'x);

        tick("c0001", 1'b0, 1'b1, 32'hC000_0001);
        check_val("c0001.const", {out_w[31:0]}, 32'h0000_0004);
        check_val("c0001.ovf1", {31'b0, ovf}, 32'd1);
        tick("3fff", 1'b0, 1'b1, 32'h3FFF_FFFF);
        check_val("3fff.const", out_w, 32'hFFFF_FFFC);
        tick("ffff", 1'b0, 1'b1, 32'hFFFF_FFFF);
        check_val("ffff.const", out_w, 32'hFFFF_FFFC);
        tick("hold_ovf", 1'b0, 1'b0, 32'd0);

        for (int i = 0; i < 8; i++) begin
            tick($sformatf("stream%0d", i), 1'b0, 1'b1, word_t'(i));
            check_val($sformatf("stream%0d.const", i), out_w, word_t'(4 * i));
        end

        tick("midrst", 1'b1, 1'b1, 32'd5);
        tick("after", 1'b0, 1'b1, 32'd6);
        check_val("after.const", out_w, 32'd24);

        for (int i = 0; i < 300; i++) begin
            d = $urandom;
            if ($urandom_range(0, 3) == 0) d[31:30] = 2'b00;
            tick($sformatf("rnd%0d", i), ($urandom_range(0, 15) == 0), ($urandom_range(0, 1) == 1), d);
        end

        tick16("p8001", 16'h8001);
        check_val("p8001.s0.const", {16'b0, o0}, 32'h8001);
        check_val("p8001.s4.const", {16'b0, o4}, 32'h0010);
        check_val("p8001.s4.ovf1", {31'b0, ov4}, 32'd1);
        for (int i = 0; i < 40; i++) begin
            tick16($sformatf("p16_%0d", i), 16'($urandom));
        end
        tick16("p0fff", 16'h0FFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
